// File: rtl/day_pkg.sv
// Shared day-of-week encodings, state enum and wrap-aware step helpers for the
// day setter and the day-display segment decoder.
package day_pkg;

  typedef logic [2:0] day_t;

  localparam day_t DAY_MON = 3'b000;
  localparam day_t DAY_TUE = 3'b001;
  localparam day_t DAY_WED = 3'b010;
  localparam day_t DAY_THU = 3'b011;
  localparam day_t DAY_FRI = 3'b100;
  localparam day_t DAY_SAT = 3'b101;
  localparam day_t DAY_SUN = 3'b110;

  localparam day_t DAY_FIRST = 3'b000;
  localparam day_t DAY_LAST  = 3'b110;

  typedef enum logic {
    RUN = 1'b0,
    SET = 1'b1
  } state_t;

  // Explicit compares keep 3'b111 unreachable from either direction.
  function automatic day_t day_inc(input day_t d);
    return (d == DAY_LAST) ? DAY_FIRST : day_t'(d + 3'd1);
  endfunction

  function automatic day_t day_dec(input day_t d);
    return (d == DAY_FIRST) ? DAY_LAST : day_t'(d - 3'd1);
  endfunction

endpackage

// File: rtl/day_setter_if.sv
// User-control and display bundle of the day setter; master drives the raw
// switch/button/carry inputs, slave (the day setter) drives the display side.
interface day_setter_if;
  import day_pkg::*;

  logic set_mode;
  logic btn_up;
  logic btn_down;
  logic day_carry;
  day_t day;
  logic day_changed;
  logic blank;

  modport master (
    output set_mode, btn_up, btn_down, day_carry,
    input  day, day_changed, blank
  );

  modport slave (
    input  set_mode, btn_up, btn_down, day_carry,
    output day, day_changed, blank
  );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioning: 2-flop synchroniser, counting debouncer and a
// registered rising-edge pulse.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_param
    $error("btn_debounce: DEBOUNCE_CYCLES out of range");
  end

  logic          sync_p0;
  logic          sync_p1;
  logic          stable;
  logic          stable_d;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0  <= 1'b0;
      sync_p1  <= 1'b0;
      stable   <= 1'b0;
      stable_d <= 1'b0;
      pulse    <= 1'b0;
      cnt      <= '0;
    end else begin
      // synchroniser stage
      sync_p0  <= btn;
      sync_p1  <= sync_p0;
      // debounce stage: any cycle of agreement restarts the count
      if (sync_p1 != stable) begin
        if (cnt == CNT_LAST) begin
          stable <= sync_p1;
          cnt    <= '0;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end else begin
        cnt <= '0;
      end
      // edge stage
      stable_d <= stable;
      pulse    <= stable & ~stable_d;
    end
  end

endmodule

// File: rtl/day_setter.sv
// Day-of-week register: advances on midnight carry in RUN, stepped by debounced
// buttons in SET. Optional set-mode blink enabled by DAY_SETTER_BLINK_EN.
module day_setter
  import day_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int BLINK_CYCLES    = 8
) (
  input logic         clk,
  input logic         rst,
  day_setter_if.slave bus
);

  if (BLINK_CYCLES < 1 || BLINK_CYCLES > 65535) begin : g_bad_param
    $error("day_setter: BLINK_CYCLES out of range");
  end

  logic   mode_p0;
  logic   mode_p1;
  logic   up_p;
  logic   dn_p;
  state_t state;
  day_t   day_q;
  day_t   day_nxt;
  logic   day_changed_q;
  logic   step;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_up),
    .pulse (up_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dn (
    .clk   (clk),
    .rst   (rst),
    .btn   (bus.btn_down),
    .pulse (dn_p)
  );

  // Carry is only honoured in RUN and buttons only in SET; nothing is queued.
  always_comb begin
    step    = 1'b0;
    day_nxt = day_q;
    if (state == RUN) begin
      if (bus.day_carry) begin
        step    = 1'b1;
        day_nxt = day_inc(day_q);
      end
    end else if (up_p && !dn_p) begin
      step    = 1'b1;
      day_nxt = day_inc(day_q);
    end else if (dn_p && !up_p) begin
      step    = 1'b1;
      day_nxt = day_dec(day_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_p0       <= 1'b0;
      mode_p1       <= 1'b0;
      state         <= RUN;
      day_q         <= DAY_MON;
      day_changed_q <= 1'b0;
    end else begin
      mode_p0       <= bus.set_mode;
      mode_p1       <= mode_p0;
      case (state)
        RUN:     if (mode_p1)  state <= SET;
        SET:     if (!mode_p1) state <= RUN;
        default: state <= RUN;
      endcase
      day_q         <= day_nxt;
      day_changed_q <= step;
    end
  end

  assign bus.day         = day_q;
  assign bus.day_changed = day_changed_q;

`ifdef DAY_SETTER_BLINK_EN
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  logic [BW-1:0] blink_cnt;
  logic          blank_q;

  // A fresh day value restarts the blink with the digit visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt <= '0;
      blank_q   <= 1'b0;
    end else if (state != SET || step) begin
      blink_cnt <= '0;
      blank_q   <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      blank_q   <= ~blank_q;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign bus.blank = blank_q;
`else
  assign bus.blank = 1'b0;
`endif

endmodule

// File: tb/tb_day_setter.sv
// Directed self-checking bench for day_setter (DEBOUNCE_CYCLES=16, BLINK_CYCLES=8).
module tb_day_setter;
  import day_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  day_setter_if bus ();

  day_setter #(.DEBOUNCE_CYCLES(16), .BLINK_CYCLES(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n posedges, sampling 1 time unit after each, counting change strobes.
  task automatic run_cycles(input int n, output int changes);
    changes = 0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.day_changed === 1'b1) changes++;
    end
  endtask

  task automatic set_mode_to(input logic m);
    int c;
    @(negedge clk);
    bus.set_mode = m;
    run_cycles(4, c);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.set_mode = 1'b0; bus.btn_up = 1'b0; bus.btn_down = 1'b0; bus.day_carry = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.day !== DAY_MON) begin failures++; $display("FAIL reset_day got=%b exp=%b", bus.day, DAY_MON); end
    checks++; if (bus.day_changed !== 1'b0) begin failures++; $display("FAIL reset_changed got=%b exp=0", bus.day_changed); end
    checks++; if (bus.blank !== 1'b0) begin failures++; $display("FAIL reset_blank got=%b exp=0", bus.blank); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_carry_run;
    day_t exp_seq [7] = '{3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110, 3'b000};
    int   c;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      bus.day_carry = 1'b1;
      @(posedge clk);
      #1;
      checks++; if (bus.day !== exp_seq[i] || bus.day_changed !== 1'b1) begin
        failures++; $display("FAIL carry_step%0d got day=%b chg=%b exp day=%b chg=1", i, bus.day, bus.day_changed, exp_seq[i]);
      end
      @(negedge clk);
      bus.day_carry = 1'b0;
      run_cycles(1, c);
      checks++; if (c !== 0) begin failures++; $display("FAIL carry_strobe_len%0d got extra=%0d exp=0", i, c); end
    end
  endtask

  task automatic test_down_press;
    int c;
    int early;
    set_mode_to(1'b1);
    @(negedge clk);
    bus.btn_down = 1'b1;
    run_cycles(19, early);
    checks++; if (early !== 0 || bus.day !== DAY_MON) begin
      failures++; $display("FAIL down_early got day=%b chg=%0d exp day=000 chg=0", bus.day, early);
    end
    @(posedge clk);
    #1;
    checks++; if (bus.day !== DAY_SUN || bus.day_changed !== 1'b1) begin
      failures++; $display("FAIL down_wrap_edge19 got day=%b chg=%b exp day=110 chg=1", bus.day, bus.day_changed);
    end
    run_cycles(20, c);
    @(negedge clk);
    bus.btn_down = 1'b0;
    begin
      int c2;
      run_cycles(25, c2);
      c += c2;
    end
    checks++; if (c !== 0 || bus.day !== DAY_SUN) begin
      failures++; $display("FAIL down_single_step got day=%b extra=%0d exp day=110 extra=0", bus.day, c);
    end
  endtask

  task automatic test_bounce;
    int c;
    int tot;
    tot = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); bus.btn_up = 1'b1; run_cycles(10, c); tot += c;
      @(negedge clk); bus.btn_up = 1'b0; run_cycles(10, c); tot += c;
    end
    run_cycles(30, c);
    tot += c;
    checks++; if (tot !== 0 || bus.day !== DAY_SUN) begin
      failures++; $display("FAIL bounce got day=%b chg=%0d exp day=110 chg=0", bus.day, tot);
    end
  endtask

  task automatic test_both_and_carry_in_set;
    int c;
    @(negedge clk);
    bus.btn_up = 1'b1; bus.btn_down = 1'b1;
    run_cycles(30, c);
    checks++; if (c !== 0 || bus.day !== DAY_SUN) begin
      failures++; $display("FAIL both_buttons got day=%b chg=%0d exp day=110 chg=0", bus.day, c);
    end
    @(negedge clk);
    bus.btn_up = 1'b0; bus.btn_down = 1'b0;
    run_cycles(25, c);
    @(negedge clk); bus.day_carry = 1'b1;
    @(negedge clk); bus.day_carry = 1'b0;
    set_mode_to(1'b0);
    run_cycles(5, c);
    checks++; if (bus.day !== DAY_SUN) begin
      failures++; $display("FAIL carry_dropped_in_set got day=%b exp=110", bus.day);
    end
    @(negedge clk); bus.day_carry = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.day !== DAY_MON || bus.day_changed !== 1'b1) begin
      failures++; $display("FAIL run_carry_wrap got day=%b chg=%b exp day=000 chg=1", bus.day, bus.day_changed);
    end
    @(negedge clk); bus.day_carry = 1'b0;
  endtask

  task automatic test_run_ignores_btn;
    int c;
    @(negedge clk); bus.btn_up = 1'b1;
    run_cycles(25, c);
    @(negedge clk); bus.btn_up = 1'b0;
    begin
      int c2;
      run_cycles(25, c2);
      c += c2;
    end
    checks++; if (c !== 0 || bus.day !== DAY_MON) begin
      failures++; $display("FAIL run_ignores_btn got day=%b chg=%0d exp day=000 chg=0", bus.day, c);
    end
  endtask

  task automatic test_up_press;
    int c;
    set_mode_to(1'b1);
    @(negedge clk); bus.btn_up = 1'b1;
    run_cycles(40, c);
    @(negedge clk); bus.btn_up = 1'b0;
    checks++; if (c !== 1 || bus.day !== DAY_TUE) begin
      failures++; $display("FAIL up_step got day=%b chg=%0d exp day=001 chg=1", bus.day, c);
    end
    run_cycles(25, c);
  endtask

  task automatic test_rst_mid_debounce;
    int c;
    set_mode_to(1'b0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); bus.day_carry = 1'b1;
      @(negedge clk); bus.day_carry = 1'b0;
    end
    #1;
    checks++; if (bus.day !== DAY_THU) begin failures++; $display("FAIL setup_thu got day=%b exp=011", bus.day); end
    set_mode_to(1'b1);
    @(negedge clk); bus.btn_up = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.day !== DAY_MON || bus.day_changed !== 1'b0) begin
      failures++; $display("FAIL rst_immediate got day=%b chg=%b exp day=000 chg=0", bus.day, bus.day_changed);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    run_cycles(5, c);
    @(negedge clk); bus.btn_up = 1'b0;
    begin
      int c2;
      run_cycles(30, c2);
      c += c2;
    end
    checks++; if (c !== 0 || bus.day !== DAY_MON) begin
      failures++; $display("FAIL rst_no_step got day=%b chg=%0d exp day=000 chg=0", bus.day, c);
    end
  endtask

  task automatic test_blink;
    int c;
    int seen_high;
`ifdef DAY_SETTER_BLINK_EN
    int wait_n;
    int hi_len;
    wait_n = 0;
    while (bus.blank !== 1'b1 && wait_n < 40) begin
      @(posedge clk); #1; wait_n++;
    end
    checks++; if (bus.blank !== 1'b1) begin failures++; $display("FAIL blink_rise got=%b exp=1 within 40 cycles", bus.blank); end
    hi_len = 0;
    while (bus.blank === 1'b1 && hi_len < 40) begin
      @(posedge clk); #1; hi_len++;
    end
    checks++; if (hi_len !== 8) begin failures++; $display("FAIL blink_period got=%0d exp=8", hi_len); end
    @(negedge clk); bus.btn_up = 1'b1;
    wait_n = 0;
    while (bus.day_changed !== 1'b1 && wait_n < 40) begin
      @(posedge clk); #1; wait_n++;
    end
    checks++; if (bus.day_changed !== 1'b1 || bus.blank !== 1'b0) begin
      failures++; $display("FAIL blink_step_clear got chg=%b blank=%b exp chg=1 blank=0", bus.day_changed, bus.blank);
    end
    @(negedge clk); bus.btn_up = 1'b0;
    run_cycles(25, c);
`else
    seen_high = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.blank !== 1'b0) seen_high++;
    end
    checks++; if (seen_high !== 0) begin failures++; $display("FAIL blank_tied_set got high_cycles=%0d exp=0", seen_high); end
`endif
    set_mode_to(1'b0);
    seen_high = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (bus.blank !== 1'b0) seen_high++;
    end
    checks++; if (seen_high !== 0) begin failures++; $display("FAIL blank_run got high_cycles=%0d exp=0", seen_high); end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_carry_run();
    test_down_press();
    test_bounce();
    test_both_and_carry_in_set();
    test_run_ignores_btn();
    test_up_press();
    test_rst_mid_debounce();
    test_blink();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
